// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (serial_in and the serial output block).
//   state_e       : receiver/transmitter state encoding
//   MODE_ONE_SHOT : i_mode value for a single word per i_start
//   MODE_REPEAT   : i_mode value for back-to-back words until i_stop
//   IDLE_LEVEL    : level of the serial line when nothing is being sent
//   majority3     : 2-of-3 vote used by the optional majority sampler
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RECV = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic MODE_ONE_SHOT = 1'b0;
  localparam logic MODE_REPEAT   = 1'b1;

  localparam logic IDLE_LEVEL = 1'b0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_sampler.sv
// Picks the value of each serial bit out of the tick-counted bit period.
// Build option: SERIAL_IN_MAJORITY_EN
//   undefined : one sample at tick count TICK_PER_BIT/2, valid on that tick
//   defined   : samples at counts HALF-1, HALF, HALF+1; the 2-of-3 vote is
//               valid on the tick at count HALF+1
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_en        : receiver is in its receive state
//   i_tick      : bit-rate enable
//   i_serial    : serial line
//   i_tick_cnt  : current tick count within the bit
//   o_bit       : sampled bit value
//   o_valid     : one-cycle pulse, o_bit should be shifted in
module serial_sampler
  import serial_pkg::*;
#(
  parameter int unsigned TICK_PER_BIT = 16,
  localparam int unsigned CW = $clog2(TICK_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_tick,
  input  logic          i_serial,
  input  logic [CW-1:0] i_tick_cnt,
  output logic          o_bit,
  output logic          o_valid
);

  localparam logic [CW-1:0] HALF = CW'(TICK_PER_BIT / 2);

  logic step;
  assign step = i_en & i_tick;

`ifdef SERIAL_IN_MAJORITY_EN
  localparam logic [CW-1:0] HALF_M1 = CW'(TICK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] HALF_P1 = CW'(TICK_PER_BIT / 2 + 1);

  logic early_q, mid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q <= IDLE_LEVEL;
      mid_q   <= IDLE_LEVEL;
    end else if (step) begin
      if (i_tick_cnt == HALF_M1) early_q <= i_serial;
      if (i_tick_cnt == HALF)    mid_q   <= i_serial;
    end
  end

  // The third vote is the live line value on the HALF+1 tick.
  assign o_bit   = majority3(early_q, mid_q, i_serial);
  assign o_valid = step & (i_tick_cnt == HALF_P1);
`else
  // Single-sample build is purely combinational; clk/rst_n are unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign o_bit   = i_serial;
  assign o_valid = step & (i_tick_cnt == HALF);
`endif

endmodule

// File: rtl/serial_in.sv
// Serial receiver: rebuilds DATA_BIT-bit words from an LSB-first, idle-low
// serial line where each bit lasts TICK_PER_BIT i_tick pulses.
// Build option: SERIAL_IN_MAJORITY_EN (3-sample majority vote, see serial_sampler).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_tick       : bit-rate enable, counted only while receiving
//   i_start      : start a frame (idle only)
//   i_stop       : abort / end repeat (any non-idle state)
//   i_mode       : MODE_ONE_SHOT or MODE_REPEAT
//   i_serial     : serial data in
//   o_data       : last completed word, held until the next one
//   o_done_tick  : one-cycle strobe, o_data valid in the same cycle
//   o_bit_tick   : one-cycle strobe after each received bit
//   o_busy       : state is not S_IDLE
module serial_in
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BIT     = 32,
  parameter int unsigned TICK_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic                i_serial,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_done_tick,
  output logic                o_bit_tick,
  output logic                o_busy
);

  localparam int unsigned TCW = $clog2(TICK_PER_BIT);
  localparam int unsigned BCW = $clog2(DATA_BIT);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_PER_BIT - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BIT - 1);

  state_e              state_q, state_d;
  logic [TCW-1:0]      tick_q, tick_d;
  logic [BCW-1:0]      bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                bit_tick_q, bit_tick_d;

  logic sample_bit, sample_valid;

  serial_sampler #(
    .TICK_PER_BIT(TICK_PER_BIT)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (state_q == S_RECV),
    .i_tick    (i_tick),
    .i_serial  (i_serial),
    .i_tick_cnt(tick_q),
    .o_bit     (sample_bit),
    .o_valid   (sample_valid)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    bit_tick_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RECV;
          tick_d  = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end

      S_RECV: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else begin
          // Right shift with MSB insert leaves the first bit at bit 0.
          if (sample_valid) shift_d = {sample_bit, shift_q[DATA_BIT-1:1]};
          if (i_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_d     = '0;
              bit_tick_d = 1'b1;
              if (bit_q == BIT_LAST) begin
                state_d = S_DONE;
              end else begin
                bit_d = bit_q + BCW'(1);
              end
            end else begin
              tick_d = tick_q + TCW'(1);
            end
          end
        end
      end

      S_DONE: begin
        // Word is delivered even when i_stop arrives here.
        data_d = shift_q;
        done_d = 1'b1;
        tick_d = '0;
        bit_d  = '0;
        if (i_stop || (i_mode == MODE_ONE_SHOT)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECV;
          shift_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign o_data      = data_q;
  assign o_done_tick = done_q;
  assign o_bit_tick  = bit_tick_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
